// File: rtl/saturn_bus_arbiter.sv
// rtl/saturn_bus_arbiter.sv - HP48 configuration daisy chain sequencer and bus read-data arbiter
//
// Ports:
//   i_clk, i_reset_n        system clock, asynchronous active-low reset
//   i_clk_en                global clock enable; all state advances only when high
//   i_bus_clk_en, i_phase   bus nibble strobe and current bus phase (address nibbles taken in phase 1)
//   i_cmd_valid, i_cmd      command pulse: 0 NONE, 1 CONFIG, 2 UNCNFG, 3 RESET
//   i_bus_nibble_in         address nibbles from the controller
//   i_mod_active/nibble/hit per-module decode, read data and configured-range hit
//   o_bus_nibble            arbitrated read nibble (highest active index wins)
//   o_cfg_addr              collected 5-nibble address
//   o_cfg_size_we/base_we   one-hot configuration strobes
//   o_uncfg_we, o_reset_we  one-hot unconfigure strobe, broadcast reset strobe
//   o_configured            per-module fully configured
//   o_busy, o_cfg_overflow  sequencer busy, sticky CONFIG-with-nothing-left flag

module saturn_bus_arbiter #(
    parameter int         NUM_MODULES  = 4,
    parameter int         ADDR_NIBBLES = 5,
    parameter logic [3:0] IDLE_NIBBLE  = 4'h0
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_clk_en,
    input  logic                      i_bus_clk_en,
    input  logic [1:0]                i_phase,
    input  logic                      i_cmd_valid,
    input  logic [1:0]                i_cmd,
    input  logic [3:0]                i_bus_nibble_in,
    input  logic [NUM_MODULES-1:0]    i_mod_active,
    input  logic [4*NUM_MODULES-1:0]  i_mod_nibble,
    input  logic [NUM_MODULES-1:0]    i_mod_hit,
    output logic [3:0]                o_bus_nibble,
    output logic [4*ADDR_NIBBLES-1:0] o_cfg_addr,
    output logic [NUM_MODULES-1:0]    o_cfg_size_we,
    output logic [NUM_MODULES-1:0]    o_cfg_base_we,
    output logic [NUM_MODULES-1:0]    o_uncfg_we,
    output logic                      o_reset_we,
    output logic [NUM_MODULES-1:0]    o_configured,
    output logic                      o_busy,
    output logic                      o_cfg_overflow
);

    localparam int CNT_W  = $clog2(ADDR_NIBBLES + 1);
    localparam int ADDR_W = 4 * ADDR_NIBBLES;

    localparam logic [1:0] CMD_CONFIG = 2'd1;
    localparam logic [1:0] CMD_UNCNFG = 2'd2;
    localparam logic [1:0] CMD_RESET  = 2'd3;

    localparam logic [1:0] STG_UNCFG = 2'd0;
    localparam logic [1:0] STG_SIZE  = 2'd1;
    localparam logic [1:0] STG_CFGD  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_APPLY,
        S_DONE
    } state_t;

    state_t                          state_q, state_d;
    logic [1:0]                      cmd_q, cmd_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [ADDR_W-1:0]               addr_q, addr_d;
    logic [NUM_MODULES-1:0][1:0]     stage_q, stage_d;
    logic                            ovf_q, ovf_d;

    logic [NUM_MODULES-1:0]          cfg_sel;
    logic                            cfg_any;
    logic [NUM_MODULES-1:0]          unc_sel;
    logic                            unc_any;

    // Lowest-index targets for CONFIG (first module not fully configured)
    // and UNCNFG (first configured module whose range contains the address).
    always_comb begin
        cfg_sel = '0;
        cfg_any = 1'b0;
        unc_sel = '0;
        unc_any = 1'b0;
        for (int k = 0; k < NUM_MODULES; k++) begin
            if (!cfg_any && (stage_q[k] < STG_CFGD)) begin
                cfg_sel[k] = 1'b1;
                cfg_any    = 1'b1;
            end
            if (!unc_any && i_mod_hit[k] && (stage_q[k] == STG_CFGD)) begin
                unc_sel[k] = 1'b1;
                unc_any    = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        stage_d       = stage_q;
        ovf_d         = ovf_q;
        o_cfg_size_we = '0;
        o_cfg_base_we = '0;
        o_uncfg_we    = '0;
        o_reset_we    = 1'b0;

        if (i_clk_en) begin
            case (state_q)
                S_IDLE: begin
                    if (i_cmd_valid) begin
                        case (i_cmd)
                            CMD_CONFIG, CMD_UNCNFG: begin
                                state_d = S_COLLECT;
                                cmd_d   = i_cmd;
                                cnt_d   = '0;
                            end
                            CMD_RESET: begin
                                state_d = S_APPLY;
                                cmd_d   = i_cmd;
                            end
                            default: ;
                        endcase
                    end
                end
                S_COLLECT: begin
                    if (i_bus_clk_en && (i_phase == 2'd1)) begin
                        for (int n = 0; n < ADDR_NIBBLES; n++) begin
                            if (cnt_q == CNT_W'(n)) begin
                                addr_d[4*n +: 4] = i_bus_nibble_in;
                            end
                        end
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(ADDR_NIBBLES - 1)) begin
                            state_d = S_APPLY;
                        end
                    end
                end
                S_APPLY: begin
                    // Strobes are qualified by i_clk_en so each is exactly one
                    // enabled cycle wide even if the enable stalls in APPLY.
                    state_d = S_DONE;
                    case (cmd_q)
                        CMD_CONFIG: begin
                            if (!cfg_any) begin
                                ovf_d = 1'b1;
                            end
                            for (int k = 0; k < NUM_MODULES; k++) begin
                                if (cfg_sel[k]) begin
                                    if (stage_q[k] == STG_UNCFG) begin
                                        o_cfg_size_we[k] = 1'b1;
                                        stage_d[k]       = STG_SIZE;
                                    end else begin
                                        o_cfg_base_we[k] = 1'b1;
                                        stage_d[k]       = STG_CFGD;
                                    end
                                end
                            end
                        end
                        CMD_UNCNFG: begin
                            for (int k = 0; k < NUM_MODULES; k++) begin
                                if (unc_sel[k]) begin
                                    o_uncfg_we[k] = 1'b1;
                                    stage_d[k]    = STG_UNCFG;
                                end
                            end
                        end
                        CMD_RESET: begin
                            o_reset_we = 1'b1;
                            stage_d    = '0;
                            ovf_d      = 1'b0;
                        end
                        default: ;
                    endcase
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            cmd_q   <= 2'd0;
            cnt_q   <= '0;
            addr_q  <= '0;
            stage_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            stage_q <= stage_d;
            ovf_q   <= ovf_d;
        end
    end

    // Later modules in the chain take priority over earlier ones.
    always_comb begin
        o_bus_nibble = IDLE_NIBBLE;
        for (int k = 0; k < NUM_MODULES; k++) begin
            if (i_mod_active[k]) begin
                o_bus_nibble = i_mod_nibble[4*k +: 4];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_MODULES; k++) begin
            o_configured[k] = (stage_q[k] == STG_CFGD);
        end
    end

    assign o_cfg_addr     = addr_q;
    assign o_busy         = (state_q != S_IDLE);
    assign o_cfg_overflow = ovf_q;

endmodule

// File: tb/tb_saturn_bus_arbiter.sv
// tb/tb_saturn_bus_arbiter.sv - directed table-driven bench for saturn_bus_arbiter

module tb_saturn_bus_arbiter;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_clk_en = 1'b1;
    logic        i_bus_clk_en = 1'b0;
    logic [1:0]  i_phase = 2'd0;
    logic        i_cmd_valid = 1'b0;
    logic [1:0]  i_cmd = 2'd0;
    logic [3:0]  i_bus_nibble_in = 4'h0;
    logic [3:0]  i_mod_active = 4'b0000;
    logic [15:0] i_mod_nibble = 16'h0000;
    logic [3:0]  i_mod_hit = 4'b0000;
    logic [3:0]  o_bus_nibble;
    logic [19:0] o_cfg_addr;
    logic [3:0]  o_cfg_size_we;
    logic [3:0]  o_cfg_base_we;
    logic [3:0]  o_uncfg_we;
    logic        o_reset_we;
    logic [3:0]  o_configured;
    logic        o_busy;
    logic        o_cfg_overflow;

    saturn_bus_arbiter #(
        .NUM_MODULES  (4),
        .ADDR_NIBBLES (5),
        .IDLE_NIBBLE  (4'h0)
    ) dut (
        .i_clk           (i_clk),
        .i_reset_n       (i_reset_n),
        .i_clk_en        (i_clk_en),
        .i_bus_clk_en    (i_bus_clk_en),
        .i_phase         (i_phase),
        .i_cmd_valid     (i_cmd_valid),
        .i_cmd           (i_cmd),
        .i_bus_nibble_in (i_bus_nibble_in),
        .i_mod_active    (i_mod_active),
        .i_mod_nibble    (i_mod_nibble),
        .i_mod_hit       (i_mod_hit),
        .o_bus_nibble    (o_bus_nibble),
        .o_cfg_addr      (o_cfg_addr),
        .o_cfg_size_we   (o_cfg_size_we),
        .o_cfg_base_we   (o_cfg_base_we),
        .o_uncfg_we      (o_uncfg_we),
        .o_reset_we      (o_reset_we),
        .o_configured    (o_configured),
        .o_busy          (o_busy),
        .o_cfg_overflow  (o_cfg_overflow)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [3:0]  active;
        logic [15:0] nibs;
        logic [3:0]  exp_nib;
    } arb_vec_t;

    typedef struct {
        logic [3:0] size_we;
        logic [3:0] base_we;
        logic [3:0] conf_after;
        logic       ovf_after;
    } cfg_vec_t;

    arb_vec_t arb_tab[7];
    cfg_vec_t cfg_tab[9];

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] CMD_CONFIG = 2'd1;
    localparam logic [1:0] CMD_UNCNFG = 2'd2;
    localparam logic [1:0] CMD_RESET  = 2'd3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] cmd);
        i_cmd_valid = 1'b1;
        i_cmd       = cmd;
        tick();
        i_cmd_valid = 1'b0;
        i_cmd       = 2'd0;
    endtask

    task automatic nib(input logic [3:0] n, input logic [1:0] ph);
        i_bus_clk_en    = 1'b1;
        i_phase         = ph;
        i_bus_nibble_in = n;
        tick();
        i_bus_clk_en    = 1'b0;
        i_phase         = 2'd0;
    endtask

    task automatic collect(input logic [19:0] a);
        for (int n = 0; n < 5; n++) begin
            nib(a[4*n +: 4], 2'd1);
        end
    endtask

    // Leaves the DUT in APPLY with strobes visible.
    task automatic do_cmd(input logic [1:0] cmd, input logic [19:0] a);
        send_cmd(cmd);
        collect(a);
    endtask

    // APPLY -> DONE -> IDLE.
    task automatic finish_cmd();
        tick();
        tick();
    endtask

    initial begin
        arb_tab[0] = '{4'b0000, 16'h5A73, 4'h0};
        arb_tab[1] = '{4'b0101, 16'h5A73, 4'hA};
        arb_tab[2] = '{4'b0001, 16'h5A73, 4'h3};
        arb_tab[3] = '{4'b1111, 16'h5A73, 4'h5};
        arb_tab[4] = '{4'b0110, 16'h5A73, 4'hA};
        arb_tab[5] = '{4'b0010, 16'h5A73, 4'h7};
        arb_tab[6] = '{4'b1001, 16'hC2E9, 4'hC};

        cfg_tab[0] = '{4'b0001, 4'b0000, 4'b0000, 1'b0};
        cfg_tab[1] = '{4'b0000, 4'b0001, 4'b0001, 1'b0};
        cfg_tab[2] = '{4'b0010, 4'b0000, 4'b0001, 1'b0};
        cfg_tab[3] = '{4'b0000, 4'b0010, 4'b0011, 1'b0};
        cfg_tab[4] = '{4'b0100, 4'b0000, 4'b0011, 1'b0};
        cfg_tab[5] = '{4'b0000, 4'b0100, 4'b0111, 1'b0};
        cfg_tab[6] = '{4'b1000, 4'b0000, 4'b0111, 1'b0};
        cfg_tab[7] = '{4'b0000, 4'b1000, 4'b1111, 1'b0};
        cfg_tab[8] = '{4'b0000, 4'b0000, 4'b1111, 1'b1};

        // Reset state
        #3;
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_configured", 32'(o_configured), 32'd0);
        chk("rst_bus_nibble", 32'(o_bus_nibble), 32'd0);
        chk("rst_overflow", 32'(o_cfg_overflow), 32'd0);
        chk("rst_addr", 32'(o_cfg_addr), 32'd0);
        chk("rst_strobes", 32'({o_cfg_size_we, o_cfg_base_we, o_uncfg_we, o_reset_we}), 32'd0);
        tick();
        i_reset_n = 1'b1;
        tick();

        // Arbitration table
        for (int i = 0; i < 7; i++) begin
            i_mod_active = arb_tab[i].active;
            i_mod_nibble = arb_tab[i].nibs;
            #1;
            chk($sformatf("arb_%0d", i), 32'(o_bus_nibble), 32'(arb_tab[i].exp_nib));
        end
        i_mod_active = 4'b0000;

        // CONFIG size then base for module 0
        do_cmd(CMD_CONFIG, 20'hFFF00);
        chk("cfg1_size_we", 32'(o_cfg_size_we), 32'h1);
        chk("cfg1_base_we", 32'(o_cfg_base_we), 32'h0);
        chk("cfg1_addr", 32'(o_cfg_addr), 32'hFFF00);
        finish_cmd();
        do_cmd(CMD_CONFIG, 20'h08000);
        chk("cfg2_base_we", 32'(o_cfg_base_we), 32'h1);
        chk("cfg2_size_we", 32'(o_cfg_size_we), 32'h0);
        chk("cfg2_addr", 32'(o_cfg_addr), 32'h08000);
        tick();
        chk("cfg2_done_busy", 32'(o_busy), 32'd1);
        chk("cfg2_done_strobe", 32'(o_cfg_base_we), 32'h0);
        tick();
        chk("cfg2_idle_busy", 32'(o_busy), 32'd0);
        chk("cfg2_configured", 32'(o_configured), 32'h1);
        chk("cfg2_addr_hold", 32'(o_cfg_addr), 32'h08000);

        // RESET: strobe one cycle after the command pulse
        send_cmd(CMD_RESET);
        chk("rst1_reset_we", 32'(o_reset_we), 32'd1);
        finish_cmd();
        chk("rst1_reset_we_gone", 32'(o_reset_we), 32'd0);
        chk("rst1_configured", 32'(o_configured), 32'h0);

        // Nine CONFIGs: fill modules in order, then overflow
        for (int i = 0; i < 9; i++) begin
            do_cmd(CMD_CONFIG, 20'(32'h10000 * i + 32'h00100));
            chk($sformatf("fill_%0d_size", i), 32'(o_cfg_size_we), 32'(cfg_tab[i].size_we));
            chk($sformatf("fill_%0d_base", i), 32'(o_cfg_base_we), 32'(cfg_tab[i].base_we));
            finish_cmd();
            chk($sformatf("fill_%0d_conf", i), 32'(o_configured), 32'(cfg_tab[i].conf_after));
            chk($sformatf("fill_%0d_ovf", i), 32'(o_cfg_overflow), 32'(cfg_tab[i].ovf_after));
        end
        send_cmd(CMD_RESET);
        chk("rst2_reset_we", 32'(o_reset_we), 32'd1);
        finish_cmd();
        chk("rst2_configured", 32'(o_configured), 32'h0);
        chk("rst2_ovf", 32'(o_cfg_overflow), 32'd0);

        // UNCNFG picks the lowest configured hit only
        for (int i = 0; i < 8; i++) begin
            do_cmd(CMD_CONFIG, 20'h08000);
            finish_cmd();
        end
        chk("unc_pre_conf", 32'(o_configured), 32'hF);
        i_mod_hit = 4'b0011;
        do_cmd(CMD_UNCNFG, 20'h08000);
        chk("unc_we", 32'(o_uncfg_we), 32'h1);
        chk("unc_addr", 32'(o_cfg_addr), 32'h08000);
        finish_cmd();
        chk("unc_conf", 32'(o_configured), 32'hE);
        // Hit only on an unconfigured module: no-op
        i_mod_hit = 4'b0001;
        do_cmd(CMD_UNCNFG, 20'h08000);
        chk("unc_nohit_we", 32'(o_uncfg_we), 32'h0);
        finish_cmd();
        chk("unc_nohit_conf", 32'(o_configured), 32'hE);
        i_mod_hit = 4'b0000;
        send_cmd(CMD_RESET);
        finish_cmd();

        // Reset asserted mid-collect aborts with no strobe
        send_cmd(CMD_CONFIG);
        nib(4'h1, 2'd1);
        nib(4'h2, 2'd1);
        nib(4'h3, 2'd1);
        i_reset_n = 1'b0;
        #1;
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_strobes", 32'({o_cfg_size_we, o_cfg_base_we, o_uncfg_we, o_reset_we}), 32'd0);
        tick();
        i_reset_n = 1'b1;
        tick();
        chk("abort_idle_busy", 32'(o_busy), 32'd0);
        do_cmd(CMD_CONFIG, 20'hFFF00);
        chk("post_abort_size", 32'(o_cfg_size_we), 32'h1);
        chk("post_abort_addr", 32'(o_cfg_addr), 32'hFFF00);
        finish_cmd();

        // Clock enable low freezes collection; off-phase nibbles and commands while busy are ignored
        send_cmd(CMD_CONFIG);
        nib(4'h5, 2'd1);
        nib(4'h4, 2'd1);
        i_clk_en = 1'b0;
        nib(4'hF, 2'd1);
        nib(4'hF, 2'd1);
        nib(4'hF, 2'd1);
        i_clk_en = 1'b1;
        nib(4'hE, 2'd2);
        send_cmd(CMD_RESET);
        nib(4'h3, 2'd1);
        nib(4'h2, 2'd1);
        chk("freeze_not_yet", 32'({o_cfg_base_we, o_reset_we}), 32'd0);
        chk("freeze_busy", 32'(o_busy), 32'd1);
        nib(4'h1, 2'd1);
        chk("freeze_base_we", 32'(o_cfg_base_we), 32'h1);
        chk("freeze_addr", 32'(o_cfg_addr), 32'h12345);
        // Stalled enable in APPLY suppresses the strobe until the enabled cycle
        i_clk_en = 1'b0;
        #1;
        chk("apply_stall_strobe", 32'(o_cfg_base_we), 32'h0);
        tick();
        chk("apply_stall_conf", 32'(o_configured), 32'h0);
        i_clk_en = 1'b1;
        #1;
        chk("apply_resume_strobe", 32'(o_cfg_base_we), 32'h1);
        finish_cmd();
        chk("freeze_conf", 32'(o_configured), 32'h1);
        chk("freeze_no_reset", 32'(o_reset_we), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
